// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a single-outstanding data-memory request.
//
// All state updates happen on the falling edge of clk so this stage lines up
// with the neighbouring pipeline registers.
//
// Ports
//   clk, rst_n               clock (negedge-active state), async active-low reset
//   ALU_result, Rt_data,     EX/MEM payload: byte address / ALU value, store data
//   RdAddr, MemW, MemR,      EX/MEM destination and controls
//   Mem2Reg, RegWrite
//   stall                    combinational; upstream holds while 1
//   dmem_req/we/addr/wdata   registered memory request
//   dmem_rdata, dmem_ack     memory response (ack is a one-cycle pulse)
//   ALU_result_out, MemData_out, RdAddr_out, RegWrite_out, Mem2Reg_out
//                            MEM/WB register
//   err_misalign, err_timeout  one-cycle error pulses
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Rt_data,
  input  logic [4:0]  RdAddr,
  input  logic        MemW,
  input  logic        MemR,
  input  logic        Mem2Reg,
  input  logic        RegWrite,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] ALU_result_out,
  output logic [31:0] MemData_out,
  output logic [4:0]  RdAddr_out,
  output logic        RegWrite_out,
  output logic        Mem2Reg_out,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  // Instruction fields held for the duration of an access; the upstream
  // inputs are not re-sampled once the request is in flight.
  logic [4:0]  hrd_q, hrd_d;
  logic        hrw_q, hrw_d;
  logic        hm2r_q, hm2r_d;
  logic        hread_q, hread_d;

  logic [31:0] wb_alu_q, wb_alu_d;
  logic [31:0] wb_md_q, wb_md_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_rw_q, wb_rw_d;
  logic        wb_m2r_q, wb_m2r_d;
  logic        emis_q, emis_d;
  logic        eto_q, eto_d;

  logic mem_op, aligned;
  assign mem_op  = MemR | MemW;
  assign aligned = (ALU_result[1:0] == 2'b00);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hrd_d    = hrd_q;
    hrw_d    = hrw_q;
    hm2r_d   = hm2r_q;
    hread_d  = hread_q;
    wb_alu_d = wb_alu_q;
    wb_md_d  = wb_md_q;
    wb_rd_d  = wb_rd_q;
    wb_rw_d  = wb_rw_q;
    wb_m2r_d = wb_m2r_q;
    emis_d   = 1'b0;
    eto_d    = 1'b0;
    stall    = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_op && aligned) begin
          stall    = 1'b1;
          req_d    = 1'b1;
          we_d     = MemW;           // MemR&MemW resolves to a write
          addr_d   = ALU_result;
          wdata_d  = Rt_data;
          cnt_d    = 4'd0;
          hrd_d    = RdAddr;
          hrw_d    = RegWrite;
          hm2r_d   = Mem2Reg;
          hread_d  = MemR & ~MemW;
          wb_rw_d  = 1'b0;           // bubble into WB
          state_d  = ACCESS;
        end else begin
          // Plain ALU op, or a misaligned access retired without a request.
          wb_alu_d = ALU_result;
          wb_rd_d  = RdAddr;
          wb_m2r_d = Mem2Reg;
          wb_rw_d  = mem_op ? 1'b0 : RegWrite;
          emis_d   = mem_op;
        end
      end
      ACCESS: begin
        // Ack wins over the timeout when both land on the last count.
        if (dmem_ack) begin
          wb_alu_d = addr_q;
          wb_rd_d  = hrd_q;
          wb_rw_d  = hrw_q;
          wb_m2r_d = hm2r_q;
          if (hread_q) wb_md_d = dmem_rdata;
          req_d    = 1'b0;
          state_d  = IDLE;
        end else if (cnt_q == 4'd15) begin
          wb_alu_d = addr_q;
          wb_rd_d  = hrd_q;
          wb_rw_d  = 1'b0;
          wb_m2r_d = hm2r_q;
          req_d    = 1'b0;
          eto_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          stall    = 1'b1;
          cnt_d    = cnt_q + 4'd1;
          wb_rw_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      hrd_q    <= 5'd0;
      hrw_q    <= 1'b0;
      hm2r_q   <= 1'b0;
      hread_q  <= 1'b0;
      wb_alu_q <= 32'd0;
      wb_md_q  <= 32'd0;
      wb_rd_q  <= 5'd0;
      wb_rw_q  <= 1'b0;
      wb_m2r_q <= 1'b0;
      emis_q   <= 1'b0;
      eto_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hrd_q    <= hrd_d;
      hrw_q    <= hrw_d;
      hm2r_q   <= hm2r_d;
      hread_q  <= hread_d;
      wb_alu_q <= wb_alu_d;
      wb_md_q  <= wb_md_d;
      wb_rd_q  <= wb_rd_d;
      wb_rw_q  <= wb_rw_d;
      wb_m2r_q <= wb_m2r_d;
      emis_q   <= emis_d;
      eto_q    <= eto_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;
  assign ALU_result_out = wb_alu_q;
  assign MemData_out    = wb_md_q;
  assign RdAddr_out     = wb_rd_q;
  assign RegWrite_out   = wb_rw_q;
  assign Mem2Reg_out    = wb_m2r_q;
  assign err_misalign   = emis_q;
  assign err_timeout    = eto_q;

endmodule
